// File: rtl/cpu_pkg.sv
// Shared datapath constants: bus width, register count and the IR field layout
// used by the register-select decode and the immediate sign extension.
package cpu_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;

    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int IMM_MSB = 18;

endpackage

// File: rtl/bus_dest_bank_reg32_en.sv
// Datapath register with synchronous clear and load enable; clear beats load.
module reg32_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bus_dest_bank.sv
// Bus destination side: decodes IR register fields into in/out strobes, latches
// BUS_data into the addressed registers and feeds their contents back to the bus sources.
module bus_dest_bank #(
    parameter int WIDTH = cpu_pkg::WIDTH,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] BUS_data,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             Read,
    input  logic             Gra,
    input  logic             Grb,
    input  logic             Grc,
    input  logic             Rin,
    input  logic             Rout,
    input  logic             BAout,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             PCin,
    input  logic             IRin,
    input  logic             MARin,
    input  logic             MDRin,
    input  logic             Yin,
    input  logic             OutPortin,
    input  logic             IncPC,
    output logic [WIDTH-1:0] r0_out,
    output logic [WIDTH-1:0] r1_out,
    output logic [WIDTH-1:0] r2_out,
    output logic [WIDTH-1:0] r3_out,
    output logic [WIDTH-1:0] r4_out,
    output logic [WIDTH-1:0] r5_out,
    output logic [WIDTH-1:0] r6_out,
    output logic [WIDTH-1:0] r7_out,
    output logic [WIDTH-1:0] r8_out,
    output logic [WIDTH-1:0] r9_out,
    output logic [WIDTH-1:0] r10_out,
    output logic [WIDTH-1:0] r11_out,
    output logic [WIDTH-1:0] r12_out,
    output logic [WIDTH-1:0] r13_out,
    output logic [WIDTH-1:0] r14_out,
    output logic [WIDTH-1:0] r15_out,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-1:0] MAR_out,
    output logic [WIDTH-1:0] MDR_out,
    output logic [WIDTH-1:0] Y_out,
    output logic [WIDTH-1:0] outPort_out,
    output logic [NREGS-1:0] rout_sel,
    output logic [WIDTH-1:0] C_sign_extended,
    output logic             multi_sel
);

    import cpu_pkg::*;

    logic [3:0]       sel_idx;
    logic             sel_valid;
    logic [NREGS-1:0] rin_sel;
    logic [WIDTH-1:0] gpr_q [NREGS];
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] mdr_d;
    logic             multi_hit;

    // Field select: Gra beats Grb beats Grc; no G* means nothing is addressed.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b1;
        if (Gra) begin
            sel_idx = IR_out[RA_MSB:RA_LSB];
        end else if (Grb) begin
            sel_idx = IR_out[RB_MSB:RB_LSB];
        end else if (Grc) begin
            sel_idx = IR_out[RC_MSB:RC_LSB];
        end else begin
            sel_valid = 1'b0;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_gpr
        assign rin_sel[i]  = Rin & sel_valid & (sel_idx == 4'(i));
        assign rout_sel[i] = (Rout | BAout) & sel_valid & (sel_idx == 4'(i));

        reg32_en #(.WIDTH(WIDTH)) u_gpr (
            .clk (clk),
            .clr (clr),
            .en  (rin_sel[i]),
            .d   (BUS_data),
            .q   (gpr_q[i])
        );
    end

    // r0 still holds its value; only its bus-facing view is zeroed for base addressing.
    assign r0_out  = BAout ? '0 : gpr_q[0];
    assign r1_out  = gpr_q[1];
    assign r2_out  = gpr_q[2];
    assign r3_out  = gpr_q[3];
    assign r4_out  = gpr_q[4];
    assign r5_out  = gpr_q[5];
    assign r6_out  = gpr_q[6];
    assign r7_out  = gpr_q[7];
    assign r8_out  = gpr_q[8];
    assign r9_out  = gpr_q[9];
    assign r10_out = gpr_q[10];
    assign r11_out = gpr_q[11];
    assign r12_out = gpr_q[12];
    assign r13_out = gpr_q[13];
    assign r14_out = gpr_q[14];
    assign r15_out = gpr_q[15];

    reg32_en #(.WIDTH(WIDTH)) u_hi  (.clk(clk), .clr(clr), .en(HIin),      .d(BUS_data), .q(HI_out));
    reg32_en #(.WIDTH(WIDTH)) u_lo  (.clk(clk), .clr(clr), .en(LOin),      .d(BUS_data), .q(LO_out));
    reg32_en #(.WIDTH(WIDTH)) u_ir  (.clk(clk), .clr(clr), .en(IRin),      .d(BUS_data), .q(IR_out));
    reg32_en #(.WIDTH(WIDTH)) u_mar (.clk(clk), .clr(clr), .en(MARin),     .d(BUS_data), .q(MAR_out));
    reg32_en #(.WIDTH(WIDTH)) u_y   (.clk(clk), .clr(clr), .en(Yin),       .d(BUS_data), .q(Y_out));
    reg32_en #(.WIDTH(WIDTH)) u_out (.clk(clk), .clr(clr), .en(OutPortin), .d(BUS_data), .q(outPort_out));

    // An explicit PC load takes precedence over the increment.
    assign pc_d  = PCin ? BUS_data : PC_out + {{(WIDTH-1){1'b0}}, 1'b1};
    assign mdr_d = Read ? Mdatain : BUS_data;

    reg32_en #(.WIDTH(WIDTH)) u_pc  (.clk(clk), .clr(clr), .en(PCin | IncPC), .d(pc_d),  .q(PC_out));
    reg32_en #(.WIDTH(WIDTH)) u_mdr (.clk(clk), .clr(clr), .en(MDRin),        .d(mdr_d), .q(MDR_out));

    assign C_sign_extended = {{(WIDTH-IMM_MSB-1){IR_out[IMM_MSB]}}, IR_out[IMM_MSB:0]};

    assign multi_hit = ((Gra & Grb) | (Gra & Grc) | (Grb & Grc)) & (Rin | Rout | BAout);

    always_ff @(posedge clk) begin
        if (clr) begin
            multi_sel <= 1'b0;
        end else if (multi_hit) begin
            multi_sel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_dest_bank.sv
// Scoreboard bench for bus_dest_bank: a driver issues directed then random cycles and
// pushes the expected outputs; a monitor pops and compares them mid-cycle.
module tb_bus_dest_bank;

    typedef struct packed {
        logic [23:0][31:0] regs;
        logic [15:0]       rout;
        logic [31:0]       csx;
        logic              multi;
    } snap_t;

    logic clk = 1'b0;
    logic clr;
    logic [31:0] bus_data, mdatain;
    logic read, gra, grb, grc, rin, rout, baout;
    logic hiin, loin, pcin, irin, marin, mdrin, yin, outportin, incpc;

    logic [31:0] o_r [16];
    logic [31:0] hi_o, lo_o, pc_o, ir_o, mar_o, mdr_o, y_o, outport_o;
    logic [15:0] rout_sel;
    logic [31:0] csx_o;
    logic        multi_o;

    // Reference state: names follow the architectural registers, not the RTL.
    logic [31:0] m_gpr [16];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_outport;
    logic        m_multi;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    stim_done = 1'b0;

    string reg_names [24] = '{"r0", "r1", "r2", "r3", "r4", "r5", "r6", "r7",
                              "r8", "r9", "r10", "r11", "r12", "r13", "r14", "r15",
                              "HI", "LO", "PC", "IR", "MAR", "MDR", "Y", "outPort"};

    always #5 clk = ~clk;

    bus_dest_bank dut (
        .clk(clk), .clr(clr), .BUS_data(bus_data), .Mdatain(mdatain), .Read(read),
        .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin), .Rout(rout), .BAout(baout),
        .HIin(hiin), .LOin(loin), .PCin(pcin), .IRin(irin), .MARin(marin),
        .MDRin(mdrin), .Yin(yin), .OutPortin(outportin), .IncPC(incpc),
        .r0_out(o_r[0]), .r1_out(o_r[1]), .r2_out(o_r[2]), .r3_out(o_r[3]),
        .r4_out(o_r[4]), .r5_out(o_r[5]), .r6_out(o_r[6]), .r7_out(o_r[7]),
        .r8_out(o_r[8]), .r9_out(o_r[9]), .r10_out(o_r[10]), .r11_out(o_r[11]),
        .r12_out(o_r[12]), .r13_out(o_r[13]), .r14_out(o_r[14]), .r15_out(o_r[15]),
        .HI_out(hi_o), .LO_out(lo_o), .PC_out(pc_o), .IR_out(ir_o), .MAR_out(mar_o),
        .MDR_out(mdr_o), .Y_out(y_o), .outPort_out(outport_o),
        .rout_sel(rout_sel), .C_sign_extended(csx_o), .multi_sel(multi_o)
    );

    task automatic idle_inputs();
        clr = 0; bus_data = '0; mdatain = '0; read = 0;
        gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
        hiin = 0; loin = 0; pcin = 0; irin = 0; marin = 0; mdrin = 0; yin = 0;
        outportin = 0; incpc = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0;
        m_mar = '0; m_mdr = '0; m_y = '0; m_outport = '0; m_multi = 1'b0;
    endtask

    // Expected outputs for the current cycle, then advance the model across the edge.
    task automatic step();
        snap_t e;
        int    sel;
        int    n_g;
        sel = -1;
        if (gra)      sel = int'(m_ir[26:23]);
        else if (grb) sel = int'(m_ir[22:19]);
        else if (grc) sel = int'(m_ir[18:15]);

        for (int i = 0; i < 16; i++) e.regs[i] = m_gpr[i];
        if (baout) e.regs[0] = '0;
        e.regs[16] = m_hi;  e.regs[17] = m_lo;  e.regs[18] = m_pc;  e.regs[19] = m_ir;
        e.regs[20] = m_mar; e.regs[21] = m_mdr; e.regs[22] = m_y;   e.regs[23] = m_outport;
        e.rout  = ((rout || baout) && sel >= 0) ? 16'(1 << sel) : 16'h0;
        e.csx   = 32'($signed(m_ir[18:0]));
        e.multi = m_multi;
        exp_q.push_back(e);

        n_g = int'(gra) + int'(grb) + int'(grc);
        if (clr) begin
            model_reset();
        end else begin
            if (rin && sel >= 0) m_gpr[sel] = bus_data;
            if (hiin)      m_hi = bus_data;
            if (loin)      m_lo = bus_data;
            if (irin)      m_ir = bus_data;
            if (marin)     m_mar = bus_data;
            if (yin)       m_y = bus_data;
            if (outportin) m_outport = bus_data;
            if (mdrin)     m_mdr = read ? mdatain : bus_data;
            if (pcin)      m_pc = bus_data;
            else if (incpc) m_pc = m_pc + 32'd1;
            if (n_g > 1 && (rin || rout || baout)) m_multi = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 24; i++) begin
                    logic [31:0] act;
                    case (i)
                        16: act = hi_o;   17: act = lo_o;  18: act = pc_o; 19: act = ir_o;
                        20: act = mar_o;  21: act = mdr_o; 22: act = y_o;  23: act = outport_o;
                        default: act = o_r[i];
                    endcase
                    checks++;
                    if (act !== e.regs[i]) begin
                        failures++;
                        $display("FAIL %s_out: got %h expected %h at %0t", reg_names[i], act, e.regs[i], $time);
                    end
                end
                checks++;
                if (rout_sel !== e.rout) begin
                    failures++;
                    $display("FAIL rout_sel: got %h expected %h at %0t", rout_sel, e.rout, $time);
                end
                checks++;
                if (csx_o !== e.csx) begin
                    failures++;
                    $display("FAIL C_sign_extended: got %h expected %h at %0t", csx_o, e.csx, $time);
                end
                checks++;
                if (multi_o !== e.multi) begin
                    failures++;
                    $display("FAIL multi_sel: got %b expected %b at %0t", multi_o, e.multi, $time);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        clr = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset overrides a same-cycle load.
        idle_inputs(); clr = 1; hiin = 1; bus_data = 32'h1234; step();
        idle_inputs(); step();

        // IR ra=1 rb=2; write r1 through Gra, then read r2's strobe through Grb.
        idle_inputs(); irin = 1; bus_data = 32'h0090_0000; step();
        idle_inputs(); gra = 1; rin = 1; bus_data = 32'hDEAD_BEEF; step();
        idle_inputs(); grb = 1; rout = 1; step();

        // ra=0: write r0=5 then base-address read gates it to zero.
        idle_inputs(); irin = 1; bus_data = 32'h0; step();
        idle_inputs(); gra = 1; rin = 1; bus_data = 32'h5; step();
        idle_inputs(); gra = 1; rout = 1; step();
        idle_inputs(); gra = 1; baout = 1; step();

        // Immediate sign extension at both edges of the 19-bit field.
        idle_inputs(); irin = 1; bus_data = 32'h0004_0000; step();
        idle_inputs(); irin = 1; bus_data = 32'h0003_FFFF; step();
        idle_inputs(); step();

        // PC wrap, PCin over IncPC, MDR memory source.
        idle_inputs(); pcin = 1; bus_data = 32'hFFFF_FFFF; step();
        idle_inputs(); incpc = 1; step();
        idle_inputs(); incpc = 1; pcin = 1; bus_data = 32'h40; step();
        idle_inputs(); mdrin = 1; read = 1; mdatain = 32'hA5; bus_data = 32'h5A; step();
        idle_inputs(); mdrin = 1; read = 0; mdatain = 32'hA5; bus_data = 32'h5A; step();
        idle_inputs(); step();

        // Multiple field selects: ra wins the write, flag is sticky until clr.
        idle_inputs(); irin = 1; bus_data = 32'h0090_0000; step();
        idle_inputs(); gra = 1; grc = 1; rin = 1; bus_data = 32'h77; step();
        idle_inputs(); step();
        idle_inputs(); step();
        idle_inputs(); clr = 1; step();
        idle_inputs(); step();

        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            clr       = ($urandom_range(0, 39) == 0);
            bus_data  = $urandom();
            mdatain   = $urandom();
            read      = 1'($urandom_range(0, 1));
            gra       = ($urandom_range(0, 2) == 0);
            grb       = ($urandom_range(0, 2) == 0);
            grc       = ($urandom_range(0, 2) == 0);
            rin       = 1'($urandom_range(0, 1));
            rout      = 1'($urandom_range(0, 1));
            baout     = ($urandom_range(0, 3) == 0);
            hiin      = ($urandom_range(0, 3) == 0);
            loin      = ($urandom_range(0, 3) == 0);
            pcin      = ($urandom_range(0, 3) == 0);
            irin      = ($urandom_range(0, 3) == 0);
            marin     = ($urandom_range(0, 3) == 0);
            mdrin     = ($urandom_range(0, 3) == 0);
            yin       = ($urandom_range(0, 3) == 0);
            outportin = ($urandom_range(0, 3) == 0);
            incpc     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) bus_data = 32'hFFFF_FFFF;
            step();
        end
        idle_inputs();
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
